// File: rtl/softmax_pkg.sv
// softmax_pkg: FSM state type and elaboration-time constant helpers shared by
// softmax_xent_grad and fixed_exp2_lut.
package softmax_pkg;

    typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_DIV, S_DONE} state_t;

    function automatic int log2e_q(input int frac);
        return int'(1.4426950408889634 * (2.0 ** frac));
    endfunction

    function automatic int sum_w(input int n, input int frac);
        return frac + 1 + $clog2(n);
    endfunction

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    // round(2^(-j/2^lut_bits) * 2^frac); entry 0 is exactly 1.0
    function automatic int lut_val(input int j, input int frac, input int lut_bits);
        return int'((2.0 ** (-real'(j) / real'(1 << lut_bits))) * (2.0 ** frac));
    endfunction

endpackage

// File: rtl/fixed_exp2_lut.sv
// fixed_exp2_lut: two-stage pipelined e^d for d <= 0 (Q.FRAC in, unsigned Q.FRAC out)
// using e^d = 2^(-t), t = -d*log2(e), split into integer shift k and LUT fraction f.
module fixed_exp2_lut
    import softmax_pkg::*;
#(
    parameter int PREC     = 16,
    parameter int FRAC     = 8,
    parameter int LUT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [PREC:0] d,
    output logic                 out_valid,
    output logic [FRAC:0]        e
);

    localparam int T_W  = PREC + FRAC + 1;
    localparam int SH   = 2 * FRAC - LUT_BITS;
    localparam int TT_W = T_W - SH;
    localparam int K_W  = TT_W - LUT_BITS;
    localparam logic [T_W-1:0] LOG2E = T_W'(log2e_q(FRAC));

    logic [FRAC:0]         lut [2**LUT_BITS];
    logic [PREC-1:0]       mag;
    logic [TT_W-1:0]       t;
    logic [K_W-1:0]        k;
    logic [LUT_BITS-1:0]   f;
    logic                  v1;

    for (genvar j = 0; j < 2**LUT_BITS; j++) begin : g_lut
        assign lut[j] = (FRAC+1)'(lut_val(j, FRAC, LUT_BITS));
    end

    // d spans PREC+1 bits so its magnitude always fits PREC unsigned bits
    assign mag = PREC'(-d);
    assign k   = t[TT_W-1:LUT_BITS];
    assign f   = t[LUT_BITS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            t         <= '0;
            e         <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            t         <= TT_W'((T_W'(mag) * LOG2E) >> SH);
            e         <= (k > K_W'(FRAC)) ? '0 : lut[f] >> k;
        end
    end

endmodule

// File: rtl/softmax_xent_grad.sv
// softmax_xent_grad: fixed-point softmax over N logits (max search, 2^x LUT exp, restoring divide).
// SOFTMAX_LABEL_GRAD_EN: emit softmax minus one-hot(label) as the cross-entropy gradient.
module softmax_xent_grad
    import softmax_pkg::*;
#(
    parameter int N_NEURONS = 10,
    parameter int PREC      = 16,
    parameter int FRAC      = 8,
    parameter int LUT_BITS  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [N_NEURONS*PREC-1:0]        act_in,
    input  logic [idx_w(N_NEURONS)-1:0]      label,
    output logic                             ready_o,
    output logic                             valid_o,
    output logic [N_NEURONS*PREC-1:0]        grad_o,
    output logic                             label_err_o
);

    localparam int SUM_W = sum_w(N_NEURONS, FRAC);
    localparam int IDX_W = idx_w(N_NEURONS);
    localparam int PTR_W = $clog2(N_NEURONS + 2);
    localparam int CNT_W = $clog2(FRAC + 2);

    state_t                  state, state_nxt;
    logic [N_NEURONS*PREC-1:0] act_r;
    logic signed [PREC-1:0]  max_r, act_sel;
    logic signed [PREC:0]    diff;
    logic [PTR_W-1:0]        ptr, sel;
    logic [CNT_W-1:0]        cnt;
    logic [SUM_W-1:0]        sum, rem_nxt;
    logic [SUM_W:0]          rem;
    logic [FRAC:0]           e_mem [N_NEURONS];
    logic [FRAC-1:0]         q;
    logic                    q_bit, last_ptr, last_step, exp_end;
    logic                    exp_in_valid, exp_valid;
    logic [FRAC:0]           exp_e;
    logic [PREC-1:0]         grad_val;

    assign ready_o      = state == S_IDLE;
    assign valid_o      = state == S_DONE;
    assign sel          = (ptr < PTR_W'(N_NEURONS)) ? ptr : '0;
    assign act_sel      = act_r[sel*PREC +: PREC];
    assign diff         = {act_sel[PREC-1], act_sel} - {max_r[PREC-1], max_r};
    assign last_ptr     = ptr == PTR_W'(N_NEURONS - 1);
    assign exp_end      = ptr == PTR_W'(N_NEURONS + 1);
    assign last_step    = cnt == CNT_W'(FRAC + 1);
    assign exp_in_valid = (state == S_EXP) && (ptr < PTR_W'(N_NEURONS));
    assign q_bit        = rem >= {1'b0, sum};
    assign rem_nxt      = q_bit ? SUM_W'(rem - {1'b0, sum}) : SUM_W'(rem);

`ifdef SOFTMAX_LABEL_GRAD_EN
    logic [IDX_W-1:0] label_r;
    // An out-of-range label never matches an element index, so nothing is subtracted
    assign grad_val = (ptr == PTR_W'(label_r)) ? PREC'({q, q_bit}) - PREC'(1 << FRAC)
                                               : PREC'({q, q_bit});
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            label_r     <= '0;
            label_err_o <= 1'b0;
        end else if (state == S_IDLE && start) begin
            label_r     <= label;
            label_err_o <= {1'b0, label} >= (IDX_W+1)'(N_NEURONS);
        end
    end
`else
    logic unused_label;
    assign unused_label = ^label;
    assign grad_val     = PREC'({q, q_bit});
    assign label_err_o  = 1'b0;
`endif

    fixed_exp2_lut #(.PREC(PREC), .FRAC(FRAC), .LUT_BITS(LUT_BITS)) u_exp (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (exp_in_valid),
        .d         (diff),
        .out_valid (exp_valid),
        .e         (exp_e)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = start ? S_MAX : S_IDLE;
            S_MAX:   state_nxt = last_ptr ? S_EXP : S_MAX;
            S_EXP:   state_nxt = exp_end ? S_DIV : S_EXP;
            S_DIV:   state_nxt = (last_step && last_ptr) ? S_DONE : S_DIV;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_r  <= '0;
            max_r  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            sum    <= '0;
            rem    <= '0;
            q      <= '0;
            grad_o <= '0;
            for (int i = 0; i < N_NEURONS; i++) e_mem[i] <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    act_r <= act_in;
                    max_r <= act_in[PREC-1:0];
                    sum   <= '0;
                    ptr   <= '0;
                end
                S_MAX: begin
                    if (act_sel > max_r) max_r <= act_sel;
                    ptr <= last_ptr ? '0 : ptr + 1'b1;
                end
                // exp results emerge two cycles after issue, hence the ptr-2 slot
                S_EXP: begin
                    if (exp_valid) begin
                        e_mem[ptr - PTR_W'(2)] <= exp_e;
                        sum <= sum + SUM_W'(exp_e);
                    end
                    ptr <= exp_end ? '0 : ptr + 1'b1;
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        rem <= (SUM_W+1)'(e_mem[sel]);
                        q   <= '0;
                        cnt <= cnt + 1'b1;
                    end else begin
                        rem <= {rem_nxt, 1'b0};
                        q   <= {q[FRAC-2:0], q_bit};
                        cnt <= last_step ? '0 : cnt + 1'b1;
                        if (last_step) begin
                            grad_o[sel*PREC +: PREC] <= grad_val;
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_xent_grad.sv
// tb_softmax_xent_grad: directed self-checking bench for softmax_xent_grad at default parameters;
// expectations follow SOFTMAX_LABEL_GRAD_EN when it is defined.
module tb_softmax_xent_grad;

    localparam int N = 10;
    localparam int W = 16;

`ifdef SOFTMAX_LABEL_GRAD_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic           clk    = 1'b0;
    logic           reset  = 1'b0;
    logic           start  = 1'b0;
    logic [N*W-1:0] act_in = '0;
    logic [3:0]     label  = '0;
    logic           ready_o, valid_o, label_err_o;
    logic [N*W-1:0] grad_o;
    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc   = 0;
    int             nv;
    logic [N*W-1:0] va, vb, vc, vd, ve;

    softmax_xent_grad dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .act_in      (act_in),
        .label       (label),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .grad_o      (grad_o),
        .label_err_o (label_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] mk(input int hot, input logic [W-1:0] hv, input logic [W-1:0] ov);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = (i == hot) ? hv : ov;
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_op(input logic [N*W-1:0] a, input logic [3:0] l);
        @(negedge clk);
        act_in = a;
        label  = l;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
    endtask

    // cyc counts cycles since the capture cycle; valid_o is due in cycle 123
    task automatic wait_valid(input string tag);
        while (valid_o !== 1'b1 && cyc < 400) step();
        chk({tag, "_lat"}, cyc, 123);
    endtask

    task automatic chk_grads(input string tag, input int hot, input int hv, input int ov, input int lbl);
        for (int i = 0; i < N; i++) begin
            int ex;
            ex = (i == hot) ? hv : ov;
            if (FEAT && i == lbl) ex -= 256;
            chk($sformatf("%s_g%0d", tag, i), 32'(signed'(grad_o[i*W +: W])), ex);
        end
        chk({tag, "_lerr"}, {31'b0, label_err_o}, (FEAT && lbl >= N) ? 1 : 0);
    endtask

    initial begin
        va = mk(0, 16'h0100, 16'h0100);
        vb = mk(0, 16'h0800, 16'hF800);
        vc = mk(2, 16'h0000, 16'hFF00);
        ve = mk(0, 16'h0000, 16'hFA73);
        for (int i = 0; i < N; i++) vd[i*W +: W] = (i == 0) ? 16'h7FFF : (i % 2 == 1) ? 16'h8000 : 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready_o}, 1);
        chk("rst_valid", {31'b0, valid_o}, 0);
        chk("rst_grad_zero", {31'b0, grad_o === '0}, 1);
        chk("rst_lerr", {31'b0, label_err_o}, 0);
        reset = 1'b1;
        // equal logits: e=1.0 each, sum=2560, q=floor(65536/2560)=25
        start_op(va, 4'd3);
        wait_valid("a");
        chk_grads("a", 0, 25, 25, 3);
        chk("a_ready_done", {31'b0, ready_o}, 0);
        step();
        chk("a_pulse", {31'b0, valid_o}, 0);
        chk("a_ready_idle", {31'b0, ready_o}, 1);
        // d=-16.0 underflows: only the max survives
        start_op(vb, 4'd0);
        wait_valid("b");
        chk_grads("b", 0, 256, 0, 0);
        // d=-1.0: k=1, f=7, LUT 189 -> e=94, sum=1102; 65536/1102=59, 24064/1102=21
        start_op(vc, 4'd9);
        wait_valid("c");
        chk_grads("c", 2, 59, 21, 9);
        // extreme logits: no wrap in the subtract
        start_op(vd, 4'd1);
        wait_valid("d");
        chk_grads("d", 0, 256, 0, 1);
        // d=-1421/256 gives k=8, f=0: e=1 (not underflow), sum=265, 65536/265=247
        start_op(ve, 4'd0);
        wait_valid("e");
        chk_grads("e", 0, 247, 0, 0);
        // start pulsed mid-DIV with different data is ignored
        start_op(vc, 4'd9);
        while (cyc < 60) step();
        act_in = vb;
        label  = 4'd0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        wait_valid("f");
        chk_grads("f", 2, 59, 21, 9);
        nv = 0;
        repeat (140) begin
            step();
            if (valid_o) nv++;
        end
        chk("f_extra_valid", nv, 0);
        // start held high through DONE: next op captured on the IDLE cycle
        start_op(va, 4'd3);
        while (cyc < 120) step();
        act_in = vc;
        label  = 4'd9;
        start  = 1'b1;
        wait_valid("g1");
        chk_grads("g1", 0, 25, 25, 3);
        step();
        chk("g_idle_ready", {31'b0, ready_o}, 1);
        chk("g_idle_valid", {31'b0, valid_o}, 0);
        step();
        start = 1'b0;
        cyc   = 1;
        wait_valid("g2");
        chk_grads("g2", 2, 59, 21, 9);
        // asynchronous reset during EXP aborts the operation
        start_op(vc, 4'd9);
        while (cyc < 15) step();
        reset = 1'b0;
        #1;
        chk("h_grad_zero", {31'b0, grad_o === '0}, 1);
        chk("h_valid", {31'b0, valid_o}, 0);
        chk("h_ready", {31'b0, ready_o}, 1);
        chk("h_lerr", {31'b0, label_err_o}, 0);
        step();
        reset = 1'b1;
        nv = 0;
        repeat (150) begin
            step();
            if (valid_o) nv++;
        end
        chk("h_no_valid", nv, 0);
        // out-of-range label: probabilities unmodified
        start_op(vc, 4'd12);
        wait_valid("h2");
        chk_grads("h2", 2, 59, 21, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
